fosfor_nibble_bus_responder: RTL

FOSFOR_NIBBLE_BUS_RESPONDER -- requirements
Module: fosfor_nibble_bus_responder

---
 rtl/fosfor_nibble_bus_responder.sv | 108 ++++++++++
 1 files changed

// File: rtl/fosfor_nibble_bus_responder.sv
// Nibble-wide bus slave: assembles bytes from LOW/HIGH phases, executes CMD codes
// against a simple register port, and returns register data or status on DataOut_b.
module fosfor_nibble_bus_responder #(
   parameter bit         TEST_REG_EN   = 1'b1,
   parameter logic [7:0] TEST_REG_ADDR = 8'hFF
) (
   input  logic       Clk_k,
   input  logic       Reset_r,
   input  logic [1:0] Address_b,
   input  logic [3:0] DataIn_b,
   output logic [7:0] DataOut_b,
   output logic [7:0] RegAddress_b,
   output logic [7:0] RegWrData_b,
   output logic       RegWrite,
   input  logic [7:0] RegRdData_b,
   output logic       Start,
   input  logic [7:0] Status_b
);

   // state      | meaning
   // PH_IDLE    | bus idle; two in a row refresh DataOut_b with status
   // PH_LOW     | low data nibble; also captures read data
   // PH_HIGH    | high data nibble
   // PH_CMD     | DataIn_b carries a command code
   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_LOW  = 2'd1,
      PH_HIGH = 2'd2,
      PH_CMD  = 2'd3
   } phase_t;

   localparam logic [3:0] CMD_NOP         = 4'd0;
   localparam logic [3:0] CMD_LATCH_ADDR  = 4'd1;
   localparam logic [3:0] CMD_WRITE       = 4'd2;
   localparam logic [3:0] CMD_START       = 4'd3;
   localparam logic [3:0] CMD_CLEAR_ERROR = 4'd4;

   phase_t     phase;
   phase_t     prev_phase;
   logic [7:0] data_q;
   logic [7:0] addr_q;
   logic [7:0] test_q;
   logic       err_q;
   logic       test_hit;
   logic [7:0] rd_data;
   logic [7:0] status;
   logic       status_unused;

   assign phase         = phase_t'(Address_b);
   assign test_hit      = TEST_REG_EN && (addr_q == TEST_REG_ADDR);
   assign rd_data       = test_hit ? test_q : RegRdData_b;
   assign status        = {err_q, Status_b[6:0]};
   assign status_unused = Status_b[7];

   assign RegAddress_b = addr_q;
   assign RegWrData_b  = data_q;

   always_ff @(posedge Clk_k) begin
      if (Reset_r) begin
         data_q     <= 8'h00;
         addr_q     <= 8'h00;
         test_q     <= 8'h00;
         err_q      <= 1'b0;
         RegWrite   <= 1'b0;
         Start      <= 1'b0;
         DataOut_b  <= 8'h00;
         prev_phase <= PH_IDLE;
      end else begin
         RegWrite   <= 1'b0;
         Start      <= 1'b0;
         prev_phase <= phase;
         case (phase)
            PH_LOW: begin
               data_q[3:0] <= DataIn_b;
               DataOut_b   <= rd_data;
            end
            PH_HIGH: data_q[7:4] <= DataIn_b;
            PH_IDLE: begin
               if (prev_phase == PH_IDLE)
                  DataOut_b <= status;
            end
            PH_CMD: begin
               case (DataIn_b)
                  CMD_NOP:        ;
                  CMD_LATCH_ADDR: addr_q <= data_q;
                  CMD_WRITE: begin
                     // writes aimed at the test register never reach the external port
                     if (test_hit)
                        test_q <= data_q;
                     else
                        RegWrite <= 1'b1;
                  end
                  CMD_START: begin
                     if (Status_b[0])
                        Start <= 1'b1;
                     else
                        err_q <= 1'b1;
                  end
                  CMD_CLEAR_ERROR: err_q <= 1'b0;
                  default:         err_q <= 1'b1;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule
